// File: rtl/oai21_cell_bist_ctrl_if.sv
// Signal bundle between the OAI21 BIST sequencer, its test-mode register block and the cell under test.
// slave = sequencer side, master = register block / cell side.
interface oai21_cell_bist_ctrl_if;
    logic       START;
    logic       ABORT;
    logic       PWR_EN;
    logic       CELL_IN1;
    logic       CELL_IN2;
    logic       CELL_IN3;
    logic       CELL_QN;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [2:0] FAIL_VEC;
    logic [3:0] FAIL_CNT;

    modport master (
        output START, ABORT, CELL_QN,
        input  PWR_EN, CELL_IN1, CELL_IN2, CELL_IN3, BUSY, DONE, PASS, FAIL_VEC, FAIL_CNT
    );

    modport slave (
        input  START, ABORT, CELL_QN,
        output PWR_EN, CELL_IN1, CELL_IN2, CELL_IN3, BUSY, DONE, PASS, FAIL_VEC, FAIL_CNT
    );
endinterface

// File: rtl/oai21_cell_bist_ctrl.sv
// BIST sequencer for one OAI21 cell: power-up, sweep all 8 input vectors, compare QN
// against ~((IN1|IN2)&IN3), report pass/fail, first failing vector and fail count.
module oai21_cell_bist_ctrl #(
    parameter int PWRUP_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input logic                    CLK,
    input logic                    RSTN,
    oai21_cell_bist_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWRUP,
        S_SETTLE,
        S_SAMPLE,
        S_REPORT
    } state_t;

    // Bit v holds the expected QN for vector v = {IN1,IN2,IN3}.
    localparam logic [7:0]  GOLDEN_QN   = 8'b0101_0111;
    localparam logic [15:0] PWRUP_LAST  = 16'(PWRUP_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] PASS_LAST   = 16'(PASSES - 1);

    logic [1:0]  rst_sync_q, rst_sync_d;
    logic        rst_int_n;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pass_cnt_q, pass_cnt_d;
    logic [2:0]  vec_q, vec_d;
    logic        pass_q, pass_d;
    logic [2:0]  fail_vec_q, fail_vec_d;
    logic [3:0]  fail_cnt_q, fail_cnt_d;
    logic        mismatch;

    // Reset asserts asynchronously, releases two edges after RSTN rises.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) rst_sync_q <= 2'b00;
        else       rst_sync_q <= rst_sync_d;
    end

    assign rst_int_n = rst_sync_q[1];

    always_ff @(posedge CLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pass_cnt_q <= '0;
            vec_q      <= '0;
            pass_q     <= 1'b0;
            fail_vec_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pass_cnt_q <= pass_cnt_d;
            vec_q      <= vec_d;
            pass_q     <= pass_d;
            fail_vec_q <= fail_vec_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign mismatch = (bus.CELL_QN != GOLDEN_QN[vec_q]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pass_cnt_d = pass_cnt_q;
        vec_d      = vec_q;
        pass_d     = pass_q;
        fail_vec_d = fail_vec_q;
        fail_cnt_d = fail_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.START && !bus.ABORT) begin
                    state_d    = S_PWRUP;
                    cnt_d      = '0;
                    pass_cnt_d = '0;
                    vec_d      = '0;
                    pass_d     = 1'b0;
                    fail_vec_d = '0;
                    fail_cnt_d = '0;
                end
            end
            S_PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (fail_cnt_q != 4'd15) fail_cnt_d = fail_cnt_q + 4'd1;
                    // A zero count means no earlier mismatch in this run.
                    if (fail_cnt_q == 4'd0)  fail_vec_d = vec_q;
                end
                if (vec_q == 3'd7) begin
                    if (pass_cnt_q == PASS_LAST) begin
                        state_d = S_REPORT;
                        pass_d  = (fail_cnt_d == 4'd0);
                    end else begin
                        state_d    = S_SETTLE;
                        vec_d      = '0;
                        pass_cnt_d = pass_cnt_q + 16'd1;
                    end
                end else begin
                    state_d = S_SETTLE;
                    vec_d   = vec_q + 3'd1;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops the run but leaves the partial failure record visible.
        if (bus.ABORT && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            pass_d     = 1'b0;
            fail_vec_d = fail_vec_q;
            fail_cnt_d = fail_cnt_q;
        end
    end

    logic drive_vec;
    assign drive_vec    = (state_q == S_SETTLE) || (state_q == S_SAMPLE);

    assign bus.PWR_EN   = (state_q == S_PWRUP) || drive_vec;
    assign bus.CELL_IN1 = drive_vec & vec_q[2];
    assign bus.CELL_IN2 = drive_vec & vec_q[1];
    assign bus.CELL_IN3 = drive_vec & vec_q[0];
    assign bus.BUSY     = (state_q != S_IDLE);
    assign bus.DONE     = (state_q == S_REPORT);
    assign bus.PASS     = pass_q;
    assign bus.FAIL_VEC = fail_vec_q;
    assign bus.FAIL_CNT = fail_cnt_q;

endmodule

// File: tb/tb_oai21_cell_bist_ctrl.sv
// Bench for oai21_cell_bist_ctrl: one instance with default parameters, one with PASSES=2,
// each driven by an OAI21 cell model with a per-vector fault mask.
module tb_oai21_cell_bist_ctrl;

    logic clk;
    logic rstn;
    int   cyc;
    int   total;
    int   bad;
    bit   cur_sel;
    logic [7:0] mask1;
    logic [7:0] mask2;

    oai21_cell_bist_ctrl_if bus1 ();
    oai21_cell_bist_ctrl_if bus2 ();

    oai21_cell_bist_ctrl #(.PWRUP_CYCLES(4), .SETTLE_CYCLES(2), .PASSES(1)) u_dut1 (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus1)
    );

    oai21_cell_bist_ctrl #(.PWRUP_CYCLES(4), .SETTLE_CYCLES(2), .PASSES(2)) u_dut2 (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus2)
    );

    function automatic logic oai21(input logic a, input logic b, input logic c);
        return ~((a | b) & c);
    endfunction

    // Cell model: ideal OAI21 with the output inverted on every vector whose mask bit is set.
    assign bus1.CELL_QN = oai21(bus1.CELL_IN1, bus1.CELL_IN2, bus1.CELL_IN3)
                          ^ mask1[{bus1.CELL_IN1, bus1.CELL_IN2, bus1.CELL_IN3}];
    assign bus2.CELL_QN = oai21(bus2.CELL_IN1, bus2.CELL_IN2, bus2.CELL_IN3)
                          ^ mask2[{bus2.CELL_IN1, bus2.CELL_IN2, bus2.CELL_IN3}];

    wire       o_done  = cur_sel ? bus2.DONE   : bus1.DONE;
    wire       o_busy  = cur_sel ? bus2.BUSY   : bus1.BUSY;
    wire       o_pass  = cur_sel ? bus2.PASS   : bus1.PASS;
    wire       o_pwr   = cur_sel ? bus2.PWR_EN : bus1.PWR_EN;
    wire [2:0] o_in    = cur_sel ? {bus2.CELL_IN1, bus2.CELL_IN2, bus2.CELL_IN3}
                                 : {bus1.CELL_IN1, bus1.CELL_IN2, bus1.CELL_IN3};
    wire [2:0] o_fvec  = cur_sel ? bus2.FAIL_VEC : bus1.FAIL_VEC;
    wire [3:0] o_fcnt  = cur_sel ? bus2.FAIL_CNT : bus1.FAIL_CNT;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) bus2.START = v;
        else     bus1.START = v;
    endtask

    // One run: START pulse, optional re-pulses at k=5 and k=10, then result checks.
    task automatic run_case(input bit sel, input logic [7:0] mask, input bit exp_pass,
                            input int exp_cnt, input int exp_vec, input int exp_lat,
                            input bit repulse, input string name);
        int  k;
        bit  found;
        cur_sel = sel;
        if (sel) mask2 = mask;
        else     mask1 = mask;
        step();
        set_start(sel, 1'b1);
        k     = 0;
        found = 0;
        while (!found && k < 400) begin
            step();
            k++;
            set_start(sel, repulse && (k == 5 || k == 10));
            if (o_done) found = 1;
        end
        set_start(sel, 1'b0);
        chk({name, "_done_lat"}, found ? k : -1, exp_lat);
        chk({name, "_pass"}, int'(o_pass), int'(exp_pass));
        chk({name, "_fail_cnt"}, int'(o_fcnt), exp_cnt);
        chk({name, "_fail_vec"}, int'(o_fvec), exp_vec);
        step();
        chk({name, "_done_pulse"}, int'(o_done), 0);
        chk({name, "_busy_after"}, int'(o_busy), 0);
        chk({name, "_pass_held"}, int'(o_pass), int'(exp_pass));
        chk({name, "_pwr_off"}, int'(o_pwr), 0);
    endtask

    typedef struct {
        bit         sel;
        logic [7:0] mask;
        bit         exp_pass;
        int         exp_cnt;
        int         exp_vec;
        int         exp_lat;
        string      name;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int   k;
        int   n_done;
        int   cnt;
        int   first;
        int   passes;
        logic [7:0] m;
        bit   sel;

        total = 0;
        bad   = 0;
        cyc   = 0;
        cur_sel = 0;
        mask1 = '0;
        mask2 = '0;
        bus1.START = 0; bus1.ABORT = 0;
        bus2.START = 0; bus2.ABORT = 0;
        rstn = 1'b0;

        tbl[0] = '{0, 8'h00, 1, 0,  0, 29, "ideal"};
        tbl[1] = '{0, 8'h57, 0, 5,  0, 29, "stuck0"};
        tbl[2] = '{0, 8'hA8, 0, 3,  3, 29, "stuck1"};
        tbl[3] = '{0, 8'h20, 0, 1,  5, 29, "vec5_only"};
        tbl[4] = '{0, 8'hFF, 0, 8,  0, 29, "all_bad"};
        tbl[5] = '{1, 8'h57, 0, 10, 0, 53, "stuck0_x2"};
        tbl[6] = '{1, 8'hFF, 0, 15, 0, 53, "saturate_x2"};
        tbl[7] = '{1, 8'h00, 1, 0,  0, 53, "ideal_x2"};

        // Reset state
        step(); step();
        chk("rst_busy", int'(bus1.BUSY), 0);
        chk("rst_pwr", int'(bus1.PWR_EN), 0);
        chk("rst_done", int'(bus1.DONE), 0);
        chk("rst_pass", int'(bus1.PASS), 0);
        chk("rst_fail_cnt", int'(bus1.FAIL_CNT), 0);
        chk("rst_fail_vec", int'(bus1.FAIL_VEC), 0);
        chk("rst_cell_in", int'({bus1.CELL_IN1, bus1.CELL_IN2, bus1.CELL_IN3}), 0);
        rstn = 1'b1;
        repeat (4) step();

        for (int i = 0; i < 8; i++)
            run_case(tbl[i].sel, tbl[i].mask, tbl[i].exp_pass, tbl[i].exp_cnt,
                     tbl[i].exp_vec, tbl[i].exp_lat, 0, tbl[i].name);

        // START re-pulsed during the run has no effect
        run_case(0, 8'h00, 1, 0, 0, 29, 1, "restart_ignored");

        // Randomized fault masks against a count/first-index model
        for (int r = 0; r < 20; r++) begin
            m      = 8'($urandom_range(0, 255));
            sel    = bit'(r % 2);
            passes = sel ? 2 : 1;
            cnt    = 0;
            first  = -1;
            for (int p = 0; p < passes; p++)
                for (int v = 0; v < 8; v++)
                    if (m[v]) begin
                        cnt++;
                        if (first < 0) first = v;
                    end
            if (cnt > 15) cnt = 15;
            run_case(sel, m, cnt == 0, cnt, (first < 0) ? 0 : first,
                     4 + passes * 24 + 1, 0, $sformatf("rand%0d", r));
        end

        // ABORT and START together in IDLE: stay idle
        cur_sel = 0;
        step();
        bus1.START = 1; bus1.ABORT = 1;
        step();
        bus1.START = 0; bus1.ABORT = 0;
        step();
        chk("abort_start_idle_busy", int'(o_busy), 0);

        // ABORT in SETTLE of vector 4
        mask1 = 8'hA8;
        bus1.START = 1;
        step();
        bus1.START = 0;
        k = 0;
        while (!(o_busy && o_in == 3'd4) && k < 100) begin
            step();
            k++;
        end
        chk("abort_reached_vec4", int'(k < 100), 1);
        bus1.ABORT = 1;
        step();
        bus1.ABORT = 0;
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_pwr", int'(o_pwr), 0);
        chk("abort_cell_in", int'(o_in), 0);
        chk("abort_pass", int'(o_pass), 0);
        chk("abort_fail_cnt", int'(o_fcnt), 1);
        chk("abort_fail_vec", int'(o_fvec), 3);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_done) n_done++;
            step();
        end
        chk("abort_no_done", n_done, 0);
        run_case(0, 8'h00, 1, 0, 0, 29, 0, "after_abort");

        // RSTN low in SAMPLE of vector 6
        mask1 = 8'h57;
        bus1.START = 1;
        step();
        bus1.START = 0;
        k = 0;
        while (!(o_busy && o_in == 3'd6) && k < 100) begin
            step();
            k++;
        end
        chk("rst_reached_vec6", int'(k < 100), 1);
        step(); step();
        chk("rst_pre_fail_cnt", int'(o_fcnt), 4);
        rstn = 1'b0;
        #1;
        chk("midrst_pwr", int'(o_pwr), 0);
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_cell_in", int'(o_in), 0);
        chk("midrst_fail_cnt", int'(o_fcnt), 0);
        chk("midrst_fail_vec", int'(o_fvec), 0);
        step(); step();
        rstn = 1'b1;
        repeat (4) step();
        chk("post_rst_busy", int'(o_busy), 0);
        chk("post_rst_pwr", int'(o_pwr), 0);
        run_case(0, 8'h00, 1, 0, 0, 29, 0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
